// File: rtl/pcie_irq_pkg.sv
// pcie_irq_pkg
//   Shared definitions for the PCIe interrupt sequencer:
//   - one-hot FSM state encoding (5 bits)
//   - upper limit on the number of user interrupt sources
//   - legacy INTx message data value
//   - round-robin pointer increment helper
package pcie_irq_pkg;

  localparam int         IRQ_CNT_MAX = 8;
  localparam logic [7:0] LEG_DI      = 8'h00;

  typedef enum logic [4:0] {
    ST_IDLE         = 5'b00001,
    ST_MSI_REQ      = 5'b00010,
    ST_LEG_ASSERT   = 5'b00100,
    ST_LEG_ACTIVE   = 5'b01000,
    ST_LEG_DEASSERT = 5'b10000
  } irq_state_e;

  // Advance a source pointer by one, wrapping after the last source index.
  function automatic logic [2:0] ptr_inc(input logic [2:0] ptr, input logic [2:0] last);
    if (ptr == last) begin
      return 3'd0;
    end else begin
      return ptr + 3'd1;
    end
  endfunction

endpackage

// File: rtl/pcie_irq_rr_arb.sv
// pcie_irq_rr_arb
//   Combinational round-robin picker. Returns the first set bit of req at or
//   after rr_ptr, wrapping modulo N.
// Ports:
//   req     in  N  request vector
//   rr_ptr  in  3  index with highest priority
//   winner  out 3  index of selected request (0 when none)
//   valid   out 1  1 when any request is set
module pcie_irq_rr_arb
  import pcie_irq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   rr_ptr,
  output logic [2:0]   winner,
  output logic         valid
);

  // Pick the requester with the smallest circular distance from rr_ptr.
  always_comb begin
    int best_d;
    int d;
    best_d = IRQ_CNT_MAX;
    d      = 0;
    winner = 3'd0;
    valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      d = (i - int'(rr_ptr) + N) % N;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        winner = 3'(i);
        valid  = 1'b1;
      end else begin
        best_d = best_d;
      end
    end
  end

endmodule

// File: rtl/pcie_irq_ctrl.sv
// pcie_irq_ctrl
//   Turns per-source user interrupt events into the endpoint core interrupt
//   handshake. MSI mode: one MSI per event, sources served round-robin.
//   Legacy mode: INTA assert/deassert message pair tracking OR of pending.
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   cfg_msi_enable           1 = MSI mode, 0 = legacy INTx
//   cfg_bus_master_en        MSI only issued when 1
//   usr_irq_set/usr_irq_clr  per-source event pulse / acknowledge
//   cfg_interrupt_rdy_n      core accepts current request when 0
//   cfg_interrupt_n          request, active-low
//   cfg_interrupt_assert_n   legacy: 0 = assert INTA, 1 = deassert
//   cfg_interrupt_di         MSI data or legacy message data
//   irq_pending              per-source pending status
//   irq_busy                 1 while the FSM is not idle
module pcie_irq_ctrl
  import pcie_irq_pkg::*;
#(
  parameter int         G_IRQ_CNT = 4,
  parameter logic [7:0] G_MSI_DI  = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_msi_enable,
  input  logic                 cfg_bus_master_en,
  input  logic [G_IRQ_CNT-1:0] usr_irq_set,
  input  logic [G_IRQ_CNT-1:0] usr_irq_clr,
  input  logic                 cfg_interrupt_rdy_n,
  output logic                 cfg_interrupt_n,
  output logic                 cfg_interrupt_assert_n,
  output logic [7:0]           cfg_interrupt_di,
  output logic [G_IRQ_CNT-1:0] irq_pending,
  output logic                 irq_busy
);

  localparam logic [2:0] LAST_IDX = 3'(G_IRQ_CNT - 1);

  irq_state_e           state;
  irq_state_e           next_state;
  logic [G_IRQ_CNT-1:0] pending;
  logic [G_IRQ_CNT-1:0] msi_req;
  logic [G_IRQ_CNT-1:0] msi_clr;
  logic [2:0]           rr_ptr;
  logic [2:0]           win;
  logic [2:0]           arb_winner;
  logic                 arb_valid;
  logic                 int_n_nxt;
  logic                 assert_n_nxt;
  logic [7:0]           di_nxt;
  logic                 busy_nxt;
  logic                 accepted;

  pcie_irq_rr_arb #(.N(G_IRQ_CNT)) u_arb (
    .req    (msi_req),
    .rr_ptr (rr_ptr),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  assign accepted    = ~cfg_interrupt_rdy_n;
  assign irq_pending = pending;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; mode is only looked at from IDLE (and LEG_ACTIVE
  // to leave legacy mode cleanly).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cfg_msi_enable && cfg_bus_master_en && arb_valid) begin
          next_state = ST_MSI_REQ;
        end else if (!cfg_msi_enable && (pending != '0)) begin
          next_state = ST_LEG_ASSERT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_MSI_REQ: begin
        if (accepted) next_state = ST_IDLE;
        else          next_state = ST_MSI_REQ;
      end
      ST_LEG_ASSERT: begin
        if (accepted) next_state = ST_LEG_ACTIVE;
        else          next_state = ST_LEG_ASSERT;
      end
      ST_LEG_ACTIVE: begin
        if ((pending == '0) || cfg_msi_enable) next_state = ST_LEG_DEASSERT;
        else                                   next_state = ST_LEG_ACTIVE;
      end
      ST_LEG_DEASSERT: begin
        if (accepted) next_state = ST_IDLE;
        else          next_state = ST_LEG_DEASSERT;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM output decode from next_state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    int_n_nxt    = 1'b1;
    assert_n_nxt = 1'b1;
    di_nxt       = LEG_DI;
    busy_nxt     = (next_state != ST_IDLE);
    case (next_state)
      ST_MSI_REQ: begin
        int_n_nxt = 1'b0;
        di_nxt    = G_MSI_DI;
      end
      ST_LEG_ASSERT: begin
        int_n_nxt    = 1'b0;
        assert_n_nxt = 1'b0;
      end
      ST_LEG_DEASSERT: begin
        int_n_nxt = 1'b0;
      end
      default: begin
        int_n_nxt = 1'b1;
      end
    endcase
  end

  // Registered core-interface outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_interrupt_n        <= 1'b1;
      cfg_interrupt_assert_n <= 1'b1;
      cfg_interrupt_di       <= 8'h00;
      irq_busy               <= 1'b0;
    end else begin
      cfg_interrupt_n        <= int_n_nxt;
      cfg_interrupt_assert_n <= assert_n_nxt;
      cfg_interrupt_di       <= di_nxt;
      irq_busy               <= busy_nxt;
    end
  end

  // msi_req bits to drop this cycle: the served winner on MSI accept, or
  // everything once legacy INTA has been asserted.
  always_comb begin
    msi_clr = '0;
    if ((state == ST_MSI_REQ) && accepted) begin
      for (int i = 0; i < G_IRQ_CNT; i++) begin
        msi_clr[i] = (3'(i) == win);
      end
    end else if (((state == ST_LEG_ASSERT) && accepted) || (state == ST_LEG_ACTIVE)) begin
      msi_clr = '1;
    end else begin
      msi_clr = '0;
    end
  end

  // Pending/msi_req registers, latched winner and round-robin pointer.
  // A new set always wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      msi_req <= '0;
      rr_ptr  <= 3'd0;
      win     <= 3'd0;
    end else begin
      pending <= (pending & ~usr_irq_clr) | usr_irq_set;
      msi_req <= (msi_req & ~msi_clr) | usr_irq_set;
      if ((state == ST_IDLE) && (next_state == ST_MSI_REQ)) begin
        win <= arb_winner;
      end else begin
        win <= win;
      end
      if ((state == ST_MSI_REQ) && accepted) begin
        rr_ptr <= ptr_inc(win, LAST_IDX);
      end else begin
        rr_ptr <= rr_ptr;
      end
    end
  end

endmodule
